// File: rtl/intr_ctrl_if.sv
// Handshake bundle between the interrupt controller and the control unit / CSR block.
// The control-unit side uses the master modport; the controller uses slave.
interface intr_ctrl_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC-1:0] IRQ;
    logic               MIE;
    logic               MASK_WE;
    logic [NUM_SRC-1:0] MASK_DIN;
    logic               INT_ACK;
    logic               INT_DONE;
    logic               INTR;
    logic [ID_W-1:0]    INT_ID;
    logic [NUM_SRC-1:0] PEND;
    logic [NUM_SRC-1:0] MASK;

    modport master (
        output IRQ, MIE, MASK_WE, MASK_DIN, INT_ACK, INT_DONE,
        input  INTR, INT_ID, PEND, MASK
    );

    modport slave (
        input  IRQ, MIE, MASK_WE, MASK_DIN, INT_ACK, INT_DONE,
        output INTR, INT_ID, PEND, MASK
    );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronise, latch, mask and prioritise NUM_SRC lines into one INTR.
// Define INTC_LEVEL_MODE_EN for level-sensitive sources (default: rising-edge sources).
module intr_ctrl #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    intr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY} state_t;

    state_t             state_q;
    logic               intr_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    sel;
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] eligible;

`ifdef INTC_LEVEL_MODE_EN
    // The pending register doubles as the second synchroniser stage, so PEND is s2.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
        end else begin
            sync1_q <= bus.IRQ;
        end
    end

    always_comb begin
        pend_d = sync1_q;
    end
`else
    logic [NUM_SRC-1:0] sync2_q, sync3_q;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] clr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= bus.IRQ;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // A new edge on the source being acknowledged must survive the clear.
    always_comb begin
        edge_det = sync2_q & ~sync3_q;
        clr      = '0;
        if (state_q == ST_REQ && bus.INT_ACK) begin
            clr[id_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | edge_det;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (bus.MASK_WE) begin
                mask_q <= bus.MASK_DIN;
            end
        end
    end

    always_comb begin
        eligible = bus.MIE ? (pend_q & mask_q) : '0;
        sel      = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (eligible[i-1]) begin
                sel = ID_W'(i - 1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (eligible != '0) begin
                        id_q    <= sel;
                        intr_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.INT_ACK) begin
                        intr_q  <= 1'b0;
                        state_q <= ST_BUSY;
                    end else if (!bus.MIE || !eligible[id_q]) begin
                        intr_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (bus.INT_DONE) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    intr_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.INTR   = intr_q;
    assign bus.INT_ID = id_q;
    assign bus.PEND   = pend_q;
    assign bus.MASK   = mask_q;
endmodule
